// File: rtl/wavegen_sequencer.sv
// wavegen_sequencer: table-driven sequencer feeding func/freq_sel/amp_sel/ld_init to the waveform generator.
// Define SEQ_LOOP_EN to wrap back to entry 0 forever instead of finishing with a done pulse.
module wavegen_sequencer #(
  parameter int AW      = 3,
  parameter int DWELL_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [8+DWELL_W-1:0] wr_data,
  input  logic [AW-1:0]        last_idx,
  input  logic                 start,
  input  logic                 abort,
  output logic                 ld_init,
  output logic [2:0]           func,
  output logic [2:0]           freq_sel,
  output logic [1:0]           amp_sel,
  output logic [AW-1:0]        cur_idx,
  output logic                 busy,
  output logic                 done
);
  localparam int EW = 8 + DWELL_W;
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2;
  logic [1:0]         state;
  logic [EW-1:0]      tbl [2**AW];
  logic [AW-1:0]      last_q;
  logic [DWELL_W-1:0] cnt;
  logic               at_last;
  logic [AW-1:0]      nxt_idx;
  logic [EW-1:0]      nxt_e;
  // A zero dwell is promoted to one cycle so the counter never wraps.
  function automatic logic [DWELL_W-1:0] dwell_of(input logic [EW-1:0] e);
    return (e[DWELL_W-1:0] == '0) ? DWELL_W'(1) : e[DWELL_W-1:0];
  endfunction
  assign busy = state != IDLE;
  always_comb begin
    at_last = cur_idx == last_q;
    nxt_idx = at_last ? '0 : cur_idx + AW'(1);
    nxt_e   = tbl[nxt_idx];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                     <= IDLE;
      last_q                    <= '0;
      cnt                       <= '0;
      cur_idx                   <= '0;
      {func, freq_sel, amp_sel} <= '0;
      ld_init                   <= 1'b0;
      done                      <= 1'b0;
      for (int i = 0; i < 2**AW; i++) tbl[i] <= '0;
    end else begin
      done    <= 1'b0;
      ld_init <= 1'b0;
      if (wr_en && !busy) tbl[wr_addr] <= wr_data;
      if (abort) begin
        state                     <= IDLE;
        cur_idx                   <= '0;
        {func, freq_sel, amp_sel} <= '0;
      end else if (state == IDLE) begin
        if (start) begin
          state                     <= LOAD;
          last_q                    <= last_idx;
          cur_idx                   <= '0;
          {func, freq_sel, amp_sel} <= tbl[0][EW-1:DWELL_W];
          ld_init                   <= 1'b1;
        end
      end else if (state == LOAD) begin
        state <= RUN;
        cnt   <= dwell_of(tbl[0]);
      end else if (cnt > DWELL_W'(1)) begin
        cnt <= cnt - DWELL_W'(1);
`ifdef SEQ_LOOP_EN
      end else begin
        cur_idx                   <= nxt_idx;
        {func, freq_sel, amp_sel} <= nxt_e[EW-1:DWELL_W];
        cnt                       <= dwell_of(nxt_e);
      end
`else
      end else if (!at_last) begin
        cur_idx                   <= nxt_idx;
        {func, freq_sel, amp_sel} <= nxt_e[EW-1:DWELL_W];
        cnt                       <= dwell_of(nxt_e);
      end else begin
        state <= IDLE;
        done  <= 1'b1;
      end
`endif
    end
  end
endmodule
